coproc_alu_arbiter: RTL and testbench

Shares one 8-bit adder and one 8-bit multiplier between two requesters: port 0 is the host port channel, port 1 is internal logic.
- A sequencing FSM runs single-step and multi-step ops (add, multiply, square-plus-offset, polynomial) through the shared datapath.
- The result is returned with the requester id.
- Sits between the port-input synchronizers and the display/port-output logic of the FPGA coprocessor.

---
 rtl/coproc_pkg.sv | 36 +++
 rtl/alu_datapath.sv | 44 ++++
 rtl/coproc_alu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_coproc_alu_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared constants for the coprocessor ALU arbiter: opcodes, FSM states,
// and per-opcode datapath step counts.
package coproc_pkg;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_MUL   = 2'd1;
    localparam logic [1:0] OP_SQADD = 2'd2;
    localparam logic [1:0] OP_POLY  = 2'd3;

    localparam logic [1:0] STEPS_ADD   = 2'd1;
    localparam logic [1:0] STEPS_MUL   = 2'd1;
    localparam logic [1:0] STEPS_SQADD = 2'd2;
    localparam logic [1:0] STEPS_POLY  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of datapath steps an opcode needs.
    function automatic logic [1:0] op_steps(input logic [1:0] op);
        case (op)
            OP_ADD:   op_steps = STEPS_ADD;
            OP_MUL:   op_steps = STEPS_MUL;
            OP_SQADD: op_steps = STEPS_SQADD;
            default:  op_steps = STEPS_POLY;
        endcase
    endfunction

    // True when the final step of an opcode is a multiply.
    function automatic logic final_is_mul(input logic [1:0] op);
        final_is_mul = (op == OP_MUL) || (op == OP_POLY);
    endfunction

endpackage

// File: rtl/alu_datapath.sv
// Shared WIDTH-bit adder and multiplier with registered results.
// Each result register only loads when its unit is used in a step, so a
// multi-step op can still read the other unit's earlier result.
module alu_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             add_en,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    input  logic             mul_en,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] add_result,
    output logic [WIDTH-1:0] mul_result
);

    logic [WIDTH-1:0] add_q, add_d;
    logic [WIDTH-1:0] mul_q, mul_d;

    // Modulo-2^WIDTH arithmetic; results truncate to WIDTH bits.
    always_comb begin
        add_d = add_q;
        mul_d = mul_q;
        if (add_en) add_d = add_a + add_b;
        if (mul_en) mul_d = mul_a * mul_b;
    end

    // Result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            add_q <= '0;
            mul_q <= '0;
        end else begin
            add_q <= add_d;
            mul_q <= mul_d;
        end
    end

    assign add_result = add_q;
    assign mul_result = mul_q;

endmodule

// File: rtl/coproc_alu_arbiter.sv
// Round-robin arbiter between two requesters sharing one adder and one
// multiplier. A small FSM sequences multi-step ops through the datapath
// and returns the result tagged with the requester id for one cycle.
module coproc_alu_arbiter
    import coproc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;

    logic             accept;
    logic             grant_id;
    logic             last_step;

    logic             add_en, mul_en;
    logic [WIDTH-1:0] add_a, add_b, mul_a, mul_b;
    logic [WIDTH-1:0] add_result, mul_result;

    // Grant selection: a lone requester wins; on contention the one not
    // granted last time wins.
    always_comb begin
        accept   = (state_q == IDLE) && (req0_valid || req1_valid);
        grant_id = 1'b0;
        if (req0_valid && req1_valid) grant_id = ~last_grant_q;
        else if (req1_valid)          grant_id = 1'b1;
    end

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    assign last_step = (step_q == 2'(op_steps(op_q) - 2'd1));

    // Operand muxing per step; units not used in a step see zero inputs.
    always_comb begin
        add_en = 1'b0;
        mul_en = 1'b0;
        add_a  = '0;
        add_b  = '0;
        mul_a  = '0;
        mul_b  = '0;
        if (state_q == EXEC) begin
            case (op_q)
                OP_ADD: begin
                    add_en = 1'b1;
                    add_a  = a_q;
                    add_b  = b_q;
                end
                OP_MUL: begin
                    mul_en = 1'b1;
                    mul_a  = a_q;
                    mul_b  = b_q;
                end
                default: begin
                    // SQADD and POLY share the a*a then +b prefix;
                    // POLY squares the sum in a third step.
                    case (step_q)
                        2'd0: begin
                            mul_en = 1'b1;
                            mul_a  = a_q;
                            mul_b  = a_q;
                        end
                        2'd1: begin
                            add_en = 1'b1;
                            add_a  = mul_result;
                            add_b  = b_q;
                        end
                        default: begin
                            mul_en = 1'b1;
                            mul_a  = add_result;
                            mul_b  = add_result;
                        end
                    endcase
                end
            endcase
        end
    end

    // Next-state logic: accept in IDLE, step through EXEC, pulse in DONE.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    step_d       = 2'd0;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    op_d         = grant_id ? req1_op : req0_op;
                    a_d          = grant_id ? req1_a  : req0_a;
                    b_d          = grant_id ? req1_b  : req0_b;
                end
            end
            EXEC: begin
                if (last_step) state_d = DONE;
                else           step_d  = step_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and latched-request registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            step_q       <= 2'd0;
            op_q         <= 2'd0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    alu_datapath #(.WIDTH(WIDTH)) u_dp (
        .clock      (clock),
        .reset_n    (reset_n),
        .add_en     (add_en),
        .add_a      (add_a),
        .add_b      (add_b),
        .mul_en     (mul_en),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .add_result (add_result),
        .mul_result (mul_result)
    );

    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = rsp_valid ? id_q : 1'b0;
    assign rsp_data  = !rsp_valid        ? '0 :
                       final_is_mul(op_q) ? mul_result : add_result;

endmodule

// File: tb/tb_coproc_alu_arbiter.sv
// Scoreboard bench: stimulus pushes expected {id,data}; a negedge monitor
// pops and compares on every rsp_valid.
module tb_coproc_alu_arbiter;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } rsp_t;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op = '0, req1_op = '0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             rsp_valid, rsp_id, busy;
    logic [WIDTH-1:0] rsp_data;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    coproc_alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every response against the scoreboard head, and
    // make sure no requester sees ready while an op is in flight.
    always @(negedge clock) begin
        if (reset_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", int'(rsp_data), -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", int'(rsp_id), int'(mon_e.id));
                chk("rsp_data", int'(rsp_data), int'(mon_e.data));
            end
        end
        if (reset_n && busy)
            chk("ready_while_busy", int'(req0_ready | req1_ready), 0);
    end

    task automatic set_req(input bit port, input bit v, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (!port) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Issue one op, check acceptance, busy and response latency N+1.
    task automatic run_op(input bit port, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp, input int n);
        bit got;
        int lat;
        @(posedge clock); #1;
        set_req(port, 1'b1, op, a, b);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (port ? req1_ready : req0_ready) begin got = 1'b1; break; end
        end
        chk("accept", int'(got), 1);
        if (!got) begin
            set_req(port, 1'b0, 2'd0, 8'd0, 8'd0);
            return;
        end
        exp_q.push_back('{id: port, data: exp});
        @(posedge clock); #1;
        set_req(port, 1'b0, 2'd0, 8'd0, 8'd0);
        chk("busy_after_accept", int'(busy), 1);
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (rsp_valid) begin lat = c; break; end
        end
        chk("latency", lat, n + 1);
        @(posedge clock); #1;
        chk("busy_back_idle", int'(busy), 0);
    endtask

    // Both requesters valid continuously with ADD a=1 b=id; grants must
    // alternate starting with requester 0.
    task automatic contend(input int n);
        int g;
        int seq[8];
        g = 0;
        @(posedge clock); #1;
        set_req(1'b0, 1'b1, 2'd0, 8'd1, 8'd0);
        set_req(1'b1, 1'b1, 2'd0, 8'd1, 8'd1);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clock);
            if (req0_ready) begin
                exp_q.push_back('{id: 1'b0, data: 8'd1}); seq[g] = 0; g++;
            end else if (req1_ready) begin
                exp_q.push_back('{id: 1'b1, data: 8'd2}); seq[g] = 1; g++;
            end
            if (g == n) break;
        end
        @(posedge clock); #1;
        set_req(1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        set_req(1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
        chk("grant_count", g, n);
        for (int i = 0; i < g; i++) chk("grant_order", seq[i], i % 2);
    endtask

    task automatic drain;
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit got;
        int lat;
        #12;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_ready", int'(req0_ready | req1_ready), 0);
        @(negedge clock); reset_n = 1'b1;
        repeat (2) @(negedge clock);

        run_op(1'b0, 2'd0, 8'd200, 8'd100, 8'd44, 1);  // ADD
        run_op(1'b1, 2'd1, 8'd20,  8'd20,  8'd144, 1); // MUL
        run_op(1'b0, 2'd2, 8'd5,   8'd3,   8'd28, 2);  // SQADD
        run_op(1'b0, 2'd3, 8'd5,   8'd3,   8'd16, 3);  // POLY
        drain();

        // Requester 1 served; meanwhile requester 0 raises valid during the
        // op and drops it again before IDLE, so only requester 1 is served next.
        @(posedge clock); #1;
        set_req(1'b1, 1'b1, 2'd0, 8'd10, 8'd20);
        @(negedge clock);
        chk("drop_first_grant", int'(req1_ready), 1);
        exp_q.push_back('{id: 1'b1, data: 8'd30});
        @(posedge clock); #1;
        set_req(1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
        set_req(1'b0, 1'b1, 2'd0, 8'd7, 8'd7);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (rsp_valid) begin got = 1'b1; break; end
        end
        chk("drop_rsp_seen", int'(got), 1);
        set_req(1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        set_req(1'b1, 1'b1, 2'd0, 8'd3, 8'd4);
        @(negedge clock);
        chk("drop_req1_ready", int'(req1_ready), 1);
        chk("drop_req0_ready", int'(req0_ready), 0);
        exp_q.push_back('{id: 1'b1, data: 8'd7});
        @(posedge clock); #1;
        set_req(1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
        drain();

        contend(4);
        drain();

        // POLY on requester 0 (last_grant becomes 0), then reset during step 1.
        @(posedge clock); #1;
        set_req(1'b0, 1'b1, 2'd3, 8'd5, 8'd3);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (req0_ready) begin got = 1'b1; break; end
        end
        chk("poly_accept", int'(got), 1);
        @(posedge clock); #1;
        set_req(1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        @(posedge clock);
        @(negedge clock);
        chk("mid_op_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_rsp_valid", int'(rsp_valid), 0);
        chk("rstmid_rsp_data", int'(rsp_data), 0);
        chk("rstmid_rsp_id", int'(rsp_id), 0);
        @(negedge clock); reset_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (rsp_valid) lat++;
        end
        chk("no_rsp_after_abort", lat, 0);

        // Priority restored to requester 0 after reset.
        contend(2);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
